// File: rtl/dcache_mem_pkg.sv
// Shared dcache constants and types; the controller and the storage array
// both import these so index/tag widths cannot diverge.
package dcache_mem_pkg;

    localparam int unsigned DCACHE_IDX_BITS  = 7;
    localparam int unsigned DCACHE_TAG_BITS  = 22;
    localparam int unsigned DCACHE_DATA_BITS = 64;
    localparam int unsigned DCACHE_LINES     = 1 << DCACHE_IDX_BITS;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_WALK = 1'b1
    } flush_state_e;

    typedef struct packed {
        logic [DCACHE_TAG_BITS-1:0]  tag;
        logic [DCACHE_DATA_BITS-1:0] data;
    } dcache_line_t;

endpackage

// File: rtl/dcache_flush_fsm.sv
// Sequential invalidate-all walker: one line cleared per cycle, then a done pulse.
module dcache_flush_fsm
    import dcache_mem_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush_req,
    output logic                       flush_busy,
    output logic                       flush_done,
    output logic                       clr_en_c,
    output logic [DCACHE_IDX_BITS-1:0] clr_idx_c
);

    localparam logic [DCACHE_IDX_BITS-1:0] LAST_IDX = {DCACHE_IDX_BITS{1'b1}};

    flush_state_e               state;
    logic [DCACHE_IDX_BITS-1:0] flush_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= FL_IDLE;
            flush_ptr  <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                FL_IDLE: begin
                    if (flush_req) begin
                        state      <= FL_WALK;
                        flush_busy <= 1'b1;
                    end
                end
                FL_WALK: begin
                    flush_ptr <= DCACHE_IDX_BITS'(flush_ptr + 1'b1);
                    if (flush_ptr == LAST_IDX) begin
                        state      <= FL_IDLE;
                        flush_busy <= 1'b0;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= FL_IDLE;
            endcase
        end
    end

    assign clr_en_c  = (state == FL_WALK);
    assign clr_idx_c = flush_ptr;

endmodule

// File: rtl/dcache_mem.sv
// Direct-mapped dcache storage: tag/data/valid per line, combinational lookup,
// fill and store write ports, plus a flush walker that invalidates every line.
module dcache_mem
    import dcache_mem_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic [DCACHE_IDX_BITS-1:0]  rd_idx,
    input  logic [DCACHE_TAG_BITS-1:0]  rd_tag,
    output logic [DCACHE_DATA_BITS-1:0] rd_data,
    output logic                        rd_valid,
    input  logic                        fill_en,
    input  logic [DCACHE_IDX_BITS-1:0]  fill_idx,
    input  logic [DCACHE_TAG_BITS-1:0]  fill_tag,
    input  logic [DCACHE_DATA_BITS-1:0] fill_data,
    input  logic                        st_en,
    input  logic [DCACHE_IDX_BITS-1:0]  st_idx,
    input  logic [DCACHE_TAG_BITS-1:0]  st_tag,
    input  logic [DCACHE_DATA_BITS-1:0] st_data,
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic                        flush_done
);

    logic [DCACHE_LINES-1:0]    valid_q;
    dcache_line_t               line_mem [DCACHE_LINES];

    logic                       clr_en_c;
    logic [DCACHE_IDX_BITS-1:0] clr_idx_c;
    logic                       wr_ok_c;
    logic                       st_we_c;
    logic                       fill_we_c;
    dcache_line_t               rd_line_c;

    dcache_flush_fsm u_flush (
        .clock      (clock),
        .reset      (reset),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .clr_en_c   (clr_en_c),
        .clr_idx_c  (clr_idx_c)
    );

    // Writes only land in idle; a flush request in the same cycle drops them.
    // On an index collision the store carries newer data, so the fill loses.
    assign wr_ok_c   = !flush_busy && !flush_req;
    assign st_we_c   = st_en && wr_ok_c;
    assign fill_we_c = fill_en && wr_ok_c && !(st_en && (st_idx == fill_idx));

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (clr_en_c)  valid_q[clr_idx_c] <= 1'b0;
            if (fill_we_c) valid_q[fill_idx]  <= 1'b1;
            if (st_we_c)   valid_q[st_idx]    <= 1'b1;
        end
    end

    // Tag/data storage is never reset; valid bits alone gate hits.
    always_ff @(posedge clock) begin
        if (fill_we_c) line_mem[fill_idx] <= '{tag: fill_tag, data: fill_data};
        if (st_we_c)   line_mem[st_idx]   <= '{tag: st_tag, data: st_data};
    end

    assign rd_line_c = line_mem[rd_idx];
    assign rd_data   = rd_line_c.data;
    assign rd_valid  = valid_q[rd_idx] && (rd_line_c.tag == rd_tag) && !flush_busy;

endmodule

// File: tb/tb_dcache_mem.sv
// Self-checking bench for dcache_mem against a line-level reference model.
module tb_dcache_mem;
    import dcache_mem_pkg::*;

    localparam int unsigned IB = DCACHE_IDX_BITS;
    localparam int unsigned TB = DCACHE_TAG_BITS;
    localparam int unsigned DB = DCACHE_DATA_BITS;
    localparam int unsigned NL = DCACHE_LINES;

    logic          clock;
    logic          reset;
    logic [IB-1:0] rd_idx;
    logic [TB-1:0] rd_tag;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic          fill_en;
    logic [IB-1:0] fill_idx;
    logic [TB-1:0] fill_tag;
    logic [DB-1:0] fill_data;
    logic          st_en;
    logic [IB-1:0] st_idx;
    logic [TB-1:0] st_tag;
    logic [DB-1:0] st_data;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;

    int errors = 0;
    int checks = 0;

    // reference model: one entry per line, plus remaining flush cycles
    bit            m_valid [NL];
    logic [TB-1:0] m_tag   [NL];
    logic [DB-1:0] m_data  [NL];
    int            flush_left = 0;
    bit            exp_done   = 0;

    dcache_mem dut (
        .clock      (clock),
        .reset      (reset),
        .rd_idx     (rd_idx),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fill_en    (fill_en),
        .fill_idx   (fill_idx),
        .fill_tag   (fill_tag),
        .fill_data  (fill_data),
        .st_en      (st_en),
        .st_idx     (st_idx),
        .st_tag     (st_tag),
        .st_data    (st_data),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit exp_hit(input int idx, input logic [TB-1:0] tag);
        return m_valid[idx] && (m_tag[idx] == tag) && (flush_left == 0);
    endfunction

    task automatic idle_inputs();
        fill_en = 1'b0; st_en = 1'b0; flush_req = 1'b0;
        fill_idx = '0; fill_tag = '0; fill_data = '0;
        st_idx = '0; st_tag = '0; st_data = '0;
    endtask

    // advance one clock, apply the behavioural rules to the model, settle
    task automatic step();
        @(posedge clock);
        exp_done = 1'b0;
        if (!reset) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            flush_left = 0;
        end else if (flush_left > 0) begin
            m_valid[NL - flush_left] = 1'b0;
            flush_left--;
            if (flush_left == 0) exp_done = 1'b1;
        end else if (flush_req) begin
            flush_left = NL;
        end else begin
            if (fill_en && !(st_en && st_idx == fill_idx)) begin
                m_valid[fill_idx] = 1'b1; m_tag[fill_idx] = fill_tag; m_data[fill_idx] = fill_data;
            end
            if (st_en) begin
                m_valid[st_idx] = 1'b1; m_tag[st_idx] = st_tag; m_data[st_idx] = st_data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b1;
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b required 0 0", flush_busy, flush_done);
        end
        for (int i = 0; i < int'(NL); i++) begin
            rd_idx = IB'(i); rd_tag = TB'($urandom); #1;
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid idx=%0d got=%b required 0", i, rd_valid);
            end
        end
    endtask

    task automatic test_fill_basic();
        fill_en = 1'b1; fill_idx = IB'(5); fill_tag = TB'(32'h1234);
        fill_data = 64'hDEADBEEF_00000001;
        step();
        idle_inputs();
        rd_idx = IB'(5); rd_tag = TB'(32'h1234); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'hDEADBEEF_00000001) begin
            errors++;
            $display("FAIL fill_hit valid=%b data=%h required 1 deadbeef00000001", rd_valid, rd_data);
        end
        rd_tag = TB'(32'h1235); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_tag_miss valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_same_idx();
        fill_en = 1'b1; fill_idx = IB'(9); fill_tag = TB'(7); fill_data = 64'hAAAA;
        st_en   = 1'b1; st_idx   = IB'(9); st_tag   = TB'(7); st_data   = 64'hBBBB;
        step();
        idle_inputs();
        rd_idx = IB'(9); rd_tag = TB'(7); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'hBBBB) begin
            errors++;
            $display("FAIL same_idx_store_wins valid=%b data=%h required 1 bbbb", rd_valid, rd_data);
        end
    endtask

    task automatic test_diff_idx();
        fill_en = 1'b1; fill_idx = IB'(3); fill_tag = TB'(32'h33); fill_data = 64'h3333_0000_3333;
        st_en   = 1'b1; st_idx   = IB'(4); st_tag   = TB'(32'h44); st_data   = 64'h4444_0000_4444;
        step();
        idle_inputs();
        rd_idx = IB'(3); rd_tag = TB'(32'h33); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h3333_0000_3333) begin
            errors++;
            $display("FAIL diff_idx_fill valid=%b data=%h required 1 333300003333", rd_valid, rd_data);
        end
        rd_idx = IB'(4); rd_tag = TB'(32'h44); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'h4444_0000_4444) begin
            errors++;
            $display("FAIL diff_idx_store valid=%b data=%h required 1 444400004444", rd_valid, rd_data);
        end
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 300; n++) begin
            fill_en   = 1'($urandom);
            fill_idx  = IB'($urandom_range(0, 15));
            fill_tag  = TB'($urandom_range(0, 3));
            fill_data = {$urandom, $urandom};
            st_en     = 1'($urandom);
            st_idx    = IB'($urandom_range(0, 15));
            st_tag    = TB'($urandom_range(0, 3));
            st_data   = {$urandom, $urandom};
            step();
            idle_inputs();
            rd_idx = IB'($urandom_range(0, 15)); rd_tag = TB'($urandom_range(0, 3)); #1;
            checks++;
            if (rd_valid !== exp_hit(int'(rd_idx), rd_tag) ||
                (rd_valid === 1'b1 && rd_data !== m_data[rd_idx])) begin
                errors++;
                $display("FAIL random_lookup idx=%0d tag=%0h valid=%b data=%h required %b %h",
                         rd_idx, rd_tag, rd_valid, rd_data, exp_hit(int'(rd_idx), rd_tag), m_data[rd_idx]);
            end
        end
    endtask

    task automatic test_flush();
        int busy_cycles = 0;
        int done_pulses = 0;
        for (int i = 0; i < 10; i++) begin
            fill_en = 1'b1; fill_idx = IB'(i * 12); fill_tag = TB'(32'h100 + i);
            fill_data = {32'hF00D0000, 32'(i)};
            step();
        end
        idle_inputs();
        // flush request together with a fill: the fill must be dropped
        flush_req = 1'b1; fill_en = 1'b1; fill_idx = IB'(127); fill_tag = TB'(9); fill_data = 64'h1;
        step();
        idle_inputs();
        for (int c = 0; c < 140; c++) begin
            if (flush_busy === 1'b1) busy_cycles++;
            if (flush_done === 1'b1) done_pulses++;
            checks++;
            if (flush_busy !== (flush_left > 0) || flush_done !== exp_done) begin
                errors++;
                $display("FAIL flush_flags cyc=%0d busy=%b done=%b required %b %b",
                         c, flush_busy, flush_done, flush_left > 0, exp_done);
            end
            rd_idx = IB'(24); rd_tag = TB'(32'h102); #1;
            checks++;
            if (rd_valid !== exp_hit(24, TB'(32'h102))) begin
                errors++;
                $display("FAIL flush_rd_valid cyc=%0d got=%b required %b", c, rd_valid, exp_hit(24, TB'(32'h102)));
            end
            idle_inputs();
            if (c == 30) flush_req = 1'b1;
            if (c == 60) begin
                st_en = 1'b1; st_idx = IB'(2); st_tag = TB'(32'h55); st_data = 64'h5555;
            end
            step();
        end
        idle_inputs();
        checks++;
        if (busy_cycles != 128 || done_pulses != 1) begin
            errors++;
            $display("FAIL flush_length busy_cycles=%0d done_pulses=%0d required 128 1", busy_cycles, done_pulses);
        end
        rd_idx = IB'(2); rd_tag = TB'(32'h55); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_store_dropped valid=%b required 0", rd_valid);
        end
        for (int i = 0; i < 10; i++) begin
            rd_idx = IB'(i * 12); rd_tag = TB'(32'h100 + i); #1;
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_cleared idx=%0d valid=%b required 0", i * 12, rd_valid);
            end
        end
        rd_idx = IB'(127); rd_tag = TB'(9); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_fill_dropped valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_reset_mid_flush();
        int done_pulses = 0;
        fill_en = 1'b1; fill_idx = IB'(100); fill_tag = TB'(32'hABC); fill_data = 64'h77;
        step();
        idle_inputs();
        flush_req = 1'b1;
        step();
        idle_inputs();
        for (int c = 1; c < 40; c++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL midflush_reset busy=%b done=%b required 0 0", flush_busy, flush_done);
        end
        for (int c = 0; c < 130; c++) begin
            if (flush_done === 1'b1) done_pulses++;
            step();
        end
        checks++;
        if (done_pulses != 0 || flush_busy !== 1'b0) begin
            errors++;
            $display("FAIL midflush_no_done pulses=%0d busy=%b required 0 0", done_pulses, flush_busy);
        end
        rd_idx = IB'(100); rd_tag = TB'(32'hABC); #1;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL midflush_invalid valid=%b required 0", rd_valid);
        end
        fill_en = 1'b1; fill_idx = IB'(0); fill_tag = TB'(32'h3FFFFF); fill_data = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        idle_inputs();
        rd_idx = IB'(0); rd_tag = TB'(32'h3FFFFF); #1;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++;
            $display("FAIL post_reset_fill valid=%b data=%h required 1 ffffffffffffffff", rd_valid, rd_data);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        rd_idx = '0;
        rd_tag = '0;
        test_reset();
        test_fill_basic();
        test_same_idx();
        test_diff_idx();
        test_random_writes();
        test_flush();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
